aes_round_seq: RTL and testbench
================================

// Module: aes_round_seq
// PURPOSE
//  Parametrised AES encryption round sequencer supporting 128/192/256-bit keys (NK=4/6/8).
//  Owns the 128-bit state register and round counter, and steps external combinational
//  SubBytes/ShiftRows/MixColumns logic and an external key-schedule unit via handshakes.
//  Adds start/ready input and valid/ready output handshakes, held ciphertext, and a watchdog abort.
// PARAMETERS
//  NK       4    key length in 32-bit words (4, 6 or 8); NR = NK+6 rounds (localparam)
//  TIMEOUT  255  max cycles waiting on sudone/keyvalid before abort (1..65535)
//  RW       4    round counter width; must satisfy 2**RW > NR
// PORTS
//  int_osc     in   1    clock
//  reset       in   1    async active-low reset
//  start       in   1    request to encrypt plaintext; accepted only when ready=1
//  ready       out  1    1 in IDLE: sequencer can accept start
//  plaintext   in   128  input block, sampled on the accepting edge
//  subbytes    in   128  SubBytes(sreg) from external S-box array
//  sudone      in   1    subbytes valid (multi-cycle S-box handshake)
//  shifted     in   128  ShiftRows(sreg), combinational
//  mixed       in   128  MixColumns(sreg), combinational
//  roundkey    in   128  round key for index key_idx
//  keyvalid    in   1    roundkey valid for current key_idx
//  key_idx     out  RW   round-key index requested (0..NR)
//  sreg        out  128  current AES state
//  round       out  RW   current round (0 in IDLE/INIT, 1..NR during rounds)
//  cvalid      out  1    ciphertext valid; held until out_ready
//  out_ready   in   1    consumer accepts ciphertext
//  ciphertext  out  128  registered result; holds last completed block
//  alarm       out  1    one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset: state=IDLE, sreg=0, round=0, ciphertext=0, cvalid=0, alarm=0, ready=1, key_idx=0.
//  - States: IDLE, INIT, SUB, SHIFT, MIX, ADDKEY, DONE. One register update per state-exit.
//  - IDLE: start&ready -> latch plaintext to sreg, round=0, go INIT. No activity on plaintext!=0.
//  - INIT: key_idx=0; wait keyvalid -> sreg=sreg^roundkey, round=1, go SUB.
//  - SUB: wait sudone -> sreg=subbytes, go SHIFT.
//  - SHIFT: sreg=shifted; go MIX if round<NR, else ADDKEY (final round skips MixColumns).
//  - MIX: sreg=mixed, go ADDKEY.
//  - ADDKEY: key_idx=round; wait keyvalid -> sreg=sreg^roundkey; round==NR -> ciphertext=sreg^roundkey,
//    go DONE; else round=round+1, go SUB.
//  - DONE: cvalid=1 (decoded from state); stay until out_ready, then IDLE (round=0). sreg keeps
//    final value; ciphertext holds until the next completion.
//  - key_idx=round in ADDKEY, 0 otherwise. ready=(state==IDLE).
//  - Latency, zero-wait handshakes: cvalid high 4*NR cycles after start-accept edge (40/48/56).
//  - Watchdog: counter clears on every state change; if in INIT/SUB/ADDKEY for TIMEOUT consecutive
//    cycles without the awaited handshake -> alarm=1 for one cycle, go IDLE; sreg=0, round=0,
//    ciphertext unchanged, cvalid never asserted for the aborted block.
//  - start while not IDLE: ignored, not queued. start and out_ready in DONE on same edge: DONE->IDLE;
//    start is taken only from IDLE on a later cycle.
//  - sudone/keyvalid outside their waiting states: ignored.
//  - reset deassert mid-block: all work discarded, returns to IDLE with reset values.
//  - round counter never exceeds NR; no wrap. Elaboration error if NK not in {4,6,8} or 2**RW<=NR.
// TESTING
//  1 NK=4, FIPS-197 C.1 pt 00112233445566778899aabbccddeeff, key 000102..0f, zero-wait
//    -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, cvalid at cycle 40 after accept.
//  2 NK=6 and NK=8, FIPS-197 C.2/C.3 -> dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089,
//    latency 48 / 56.
//  3 NK=4, Appendix B pt 3243f6a8885a308d313198a2e0370734 with sudone 3-cycle and keyvalid random
//    stalls -> 3925841d02dc09fbdc118597196a0b32; latency 40 + total stall cycles.
//  4 Hold out_ready=0 for 10 cycles in DONE, pulse start -> cvalid stays, ciphertext stable, start ignored;
//    out_ready=1 -> IDLE next cycle, ready=1.
//  5 TIMEOUT=8, keyvalid stuck 0 in round 3 ADDKEY -> alarm one-cycle pulse at 8th wait cycle,
//    state IDLE, ciphertext keeps previous value, no cvalid.
//  6 Assert reset at round 5 -> all outputs at reset values asynchronously; next start runs full
//    block correctly.

Source files
------------

// File: rtl/aes_round_seq_if.sv
//------------------------------------------------------------------------------
// aes_round_seq_if : handshake and data bus between the AES round sequencer and
//                    its datapath / key-schedule / consumer environment
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface aes_round_seq_if #(
   parameter int RW = 4
);
   logic          start;
   logic          ready;
   logic [127:0]  plaintext;
   logic [127:0]  subbytes;
   logic          sudone;
   logic [127:0]  shifted;
   logic [127:0]  mixed;
   logic [127:0]  roundkey;
   logic          keyvalid;
   logic [RW-1:0] key_idx;
   logic [127:0]  sreg;
   logic [RW-1:0] round;
   logic          cvalid;
   logic          out_ready;
   logic [127:0]  ciphertext;
   logic          alarm;

   modport master (
      output start, plaintext, subbytes, sudone, shifted, mixed, roundkey, keyvalid, out_ready,
      input  ready, key_idx, sreg, round, cvalid, ciphertext, alarm
   );

   modport slave (
      input  start, plaintext, subbytes, sudone, shifted, mixed, roundkey, keyvalid, out_ready,
      output ready, key_idx, sreg, round, cvalid, ciphertext, alarm
   );
endinterface

`default_nettype wire

// File: rtl/aes_round_seq.sv
//------------------------------------------------------------------------------
// aes_round_seq : AES encryption round sequencer (NK=4/6/8) stepping external
//                 S-box, ShiftRows, MixColumns and key-schedule units
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aes_round_seq #(
   parameter int NK      = 4,
   parameter int TIMEOUT = 255,
   parameter int RW      = 4
) (
   input  logic            int_osc,
   input  logic            reset,
   aes_round_seq_if.slave  bus
);
   localparam int NR = NK + 6;
   localparam logic [RW-1:0] NR_R    = RW'(NR);
   localparam logic [15:0]   WD_LAST = 16'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_SUB    = 3'd2;
   localparam logic [2:0] S_SHIFT  = 3'd3;
   localparam logic [2:0] S_MIX    = 3'd4;
   localparam logic [2:0] S_ADDKEY = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   generate
      if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
         $error("aes_round_seq: NK must be 4, 6 or 8");
      end
      if ((2 ** RW) <= NR) begin : g_bad_rw
         $error("aes_round_seq: RW too narrow for NR");
      end
      if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
         $error("aes_round_seq: TIMEOUT must be 1..65535");
      end
   endgenerate

   logic [2:0]    state_q, state_d;
   logic [127:0]  sreg_q, sreg_d;
   logic [127:0]  ct_q, ct_d;
   logic [RW-1:0] round_q, round_d;
   logic [15:0]   wd_q, wd_d;
   logic          alarm_q, alarm_d;
   logic          waiting;
   logic          handshake;

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      ct_d      = ct_q;
      round_d   = round_q;
      alarm_d   = 1'b0;
      wd_d      = 16'd0;
      waiting   = (state_q == S_INIT) || (state_q == S_SUB) || (state_q == S_ADDKEY);
      handshake = (state_q == S_SUB) ? bus.sudone : bus.keyvalid;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               sreg_d  = bus.plaintext;
               round_d = '0;
               state_d = S_INIT;
            end
         end
         S_INIT: begin
            if (bus.keyvalid) begin
               sreg_d  = sreg_q ^ bus.roundkey;
               round_d = RW'(1);
               state_d = S_SUB;
            end
         end
         S_SUB: begin
            if (bus.sudone) begin
               sreg_d  = bus.subbytes;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sreg_d  = bus.shifted;
            // The last round has no MixColumns step.
            state_d = (round_q < NR_R) ? S_MIX : S_ADDKEY;
         end
         S_MIX: begin
            sreg_d  = bus.mixed;
            state_d = S_ADDKEY;
         end
         S_ADDKEY: begin
            if (bus.keyvalid) begin
               sreg_d = sreg_q ^ bus.roundkey;
               if (round_q == NR_R) begin
                  ct_d    = sreg_q ^ bus.roundkey;
                  state_d = S_DONE;
               end else begin
                  round_d = round_q + RW'(1);
                  state_d = S_SUB;
               end
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               round_d = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Watchdog overrides the stalled wait; the block in flight is dropped.
      if (waiting && !handshake) begin
         if (wd_q == WD_LAST) begin
            state_d = S_IDLE;
            sreg_d  = '0;
            round_d = '0;
            alarm_d = 1'b1;
         end else begin
            wd_d = wd_q + 16'd1;
         end
      end
   end

   always_ff @(posedge int_osc or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         ct_q    <= '0;
         round_q <= '0;
         wd_q    <= 16'd0;
         alarm_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         ct_q    <= ct_d;
         round_q <= round_d;
         wd_q    <= wd_d;
         alarm_q <= alarm_d;
      end
   end

   assign bus.ready      = (state_q == S_IDLE);
   assign bus.cvalid     = (state_q == S_DONE);
   assign bus.key_idx    = (state_q == S_ADDKEY) ? round_q : '0;
   assign bus.sreg       = sreg_q;
   assign bus.round      = round_q;
   assign bus.ciphertext = ct_q;
   assign bus.alarm      = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_seq.sv
//------------------------------------------------------------------------------
// tb_aes_round_seq : directed bench for aes_round_seq with a behavioural AES
//                    datapath/key-schedule environment and FIPS-197 vectors
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_aes_round_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   aes_round_seq_if #(.RW(4)) b4 ();
   aes_round_seq_if #(.RW(4)) b6 ();
   aes_round_seq_if #(.RW(4)) b8 ();

   aes_round_seq #(.NK(4), .TIMEOUT(8), .RW(4)) dut4 (.int_osc(clk), .reset(rst_n), .bus(b4));
   aes_round_seq #(.NK(6), .RW(4))              dut6 (.int_osc(clk), .reset(rst_n), .bus(b6));
   aes_round_seq #(.NK(8), .RW(4))              dut8 (.int_osc(clk), .reset(rst_n), .bus(b8));

   // ---------------- behavioural AES helpers ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sb(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gm(r, r);
         if (i != 0) r = gm(r, a);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*(4*c)   -: 8];
         a1 = s[127-8*(4*c+1) -: 8];
         a2 = s[127-8*(4*c+2) -: 8];
         a3 = s[127-8*(4*c+3) -: 8];
         o[127-8*(4*c)   -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
         o[127-8*(4*c+1) -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
         o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
         o[127-8*(4*c+3) -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end
      return o;
   endfunction

   task automatic expand(input logic [255:0] key, input int nk, output logic [127:0] rk [16]);
      logic [31:0] w [64];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 64; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k < 16; k++)
         rk[k] = (k < nk + 7) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
   endtask

   // ---------------- environment ----------------
   logic [127:0] rk4 [16];
   logic [127:0] rk6 [16];
   logic [127:0] rk8 [16];
   logic         st_r [3];
   logic [127:0] pt_r [3];
   logic         ordy_r [3];
   int           mode4 = 0;    // 0 zero-wait, 1 stalls, 2 key 3 never valid
   int           kst [16];
   int           scnt = 0;
   int           kcnt = 0;
   logic [127:0] last_s = '0;
   logic         req4;

   assign req4 = (!b4.ready && !b4.cvalid && b4.round == 4'd0) || (b4.key_idx != 4'd0);

   always @(negedge clk) begin
      scnt   <= (b4.sreg === last_s) ? scnt + 1 : 0;
      last_s <= b4.sreg;
      kcnt   <= req4 ? kcnt + 1 : 0;
   end

   assign b4.start     = st_r[0];
   assign b4.plaintext = pt_r[0];
   assign b4.out_ready = ordy_r[0];
   assign b4.subbytes  = sub_bytes(b4.sreg);
   assign b4.shifted   = shift_rows(b4.sreg);
   assign b4.mixed     = mix_cols(b4.sreg);
   assign b4.roundkey  = rk4[b4.key_idx];
   assign b4.sudone    = (mode4 == 1) ? (scnt >= 3) : 1'b1;
   assign b4.keyvalid  = (mode4 == 0) ? 1'b1 :
                         (mode4 == 1) ? (req4 && (kcnt > kst[b4.key_idx])) :
                                        (b4.key_idx != 4'd3);

   assign b6.start     = st_r[1];
   assign b6.plaintext = pt_r[1];
   assign b6.out_ready = ordy_r[1];
   assign b6.subbytes  = sub_bytes(b6.sreg);
   assign b6.shifted   = shift_rows(b6.sreg);
   assign b6.mixed     = mix_cols(b6.sreg);
   assign b6.roundkey  = rk6[b6.key_idx];
   assign b6.sudone    = 1'b1;
   assign b6.keyvalid  = 1'b1;

   assign b8.start     = st_r[2];
   assign b8.plaintext = pt_r[2];
   assign b8.out_ready = ordy_r[2];
   assign b8.subbytes  = sub_bytes(b8.sreg);
   assign b8.shifted   = shift_rows(b8.sreg);
   assign b8.mixed     = mix_cols(b8.sreg);
   assign b8.roundkey  = rk8[b8.key_idx];
   assign b8.sudone    = 1'b1;
   assign b8.keyvalid  = 1'b1;

   function automatic logic rdy(input int u);
      return (u == 0) ? b4.ready : (u == 1) ? b6.ready : b8.ready;
   endfunction
   function automatic logic cv(input int u);
      return (u == 0) ? b4.cvalid : (u == 1) ? b6.cvalid : b8.cvalid;
   endfunction
   function automatic logic [127:0] cto(input int u);
      return (u == 0) ? b4.ciphertext : (u == 1) ? b6.ciphertext : b8.ciphertext;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input int u, input logic [127:0] pt, output int lat, output logic [127:0] ct);
      int n;
      n = 0;
      @(negedge clk);
      while (!rdy(u) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("run_ready", 128'(rdy(u)), 128'(1));
      pt_r[u] = pt;
      st_r[u] = 1'b1;
      @(posedge clk);
      #1 st_r[u] = 1'b0;
      lat = 0;
      while (!cv(u) && lat < 2000) begin
         @(posedge clk);
         #1;
         lat++;
      end
      ct = cto(u);
   endtask

   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_B = 256'h2b7e151628aed2a6abf7158809cf4f3c00000000000000000000000000000000;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

   initial begin
      int lat;
      int n;
      int stall_sum;
      logic [127:0] ct;

      for (int i = 0; i < 3; i++) begin
         st_r[i]   = 1'b0;
         pt_r[i]   = '0;
         ordy_r[i] = 1'b1;
      end
      for (int i = 0; i < 16; i++) kst[i] = 0;
      expand(KEY_C, 4, rk4);
      expand(KEY_C, 6, rk6);
      expand(KEY_C, 8, rk8);

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", 128'(b4.ready), 128'(1));
      chk("rst_cvalid", 128'(b4.cvalid), 128'(0));
      chk("rst_sreg", b4.sreg, 128'h0);
      chk("rst_round", 128'(b4.round), 128'(0));
      chk("rst_ct", b4.ciphertext, 128'h0);
      chk("rst_keyidx", 128'(b4.key_idx), 128'(0));
      chk("rst_alarm", 128'(b4.alarm), 128'(0));
      rst_n = 1'b1;

      // FIPS-197 C.1 / C.2 / C.3, zero-wait
      run(0, PT_C, lat, ct);
      chk("c1_ct", ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("c1_lat", 128'(lat), 128'(40));
      run(1, PT_C, lat, ct);
      chk("c2_ct", ct, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      chk("c2_lat", 128'(lat), 128'(48));
      run(2, PT_C, lat, ct);
      chk("c3_ct", ct, 128'h8ea2b7ca516745bfeafc49904b496089);
      chk("c3_lat", 128'(lat), 128'(56));

      // Appendix B with S-box and key-schedule stalls; stays in DONE
      expand(KEY_B, 4, rk4);
      stall_sum = 30;
      for (int i = 0; i <= 10; i++) begin
         kst[i] = int'($urandom_range(0, 5));
         stall_sum += kst[i];
      end
      mode4 = 1;
      ordy_r[0] = 1'b0;
      run(0, PT_B, lat, ct);
      chk("b_stall_ct", ct, CT_B);
      chk("b_stall_lat", 128'(lat), 128'(40 + stall_sum));

      // Held in DONE, start pulse ignored
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_cvalid", 128'(b4.cvalid), 128'(1));
         chk("hold_ct", b4.ciphertext, CT_B);
         st_r[0] = (i == 4);
      end
      @(negedge clk);
      st_r[0] = 1'b0;
      chk("hold_after_start", 128'(b4.cvalid), 128'(1));
      ordy_r[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("release_ready", 128'(b4.ready), 128'(1));
      chk("release_cvalid", 128'(b4.cvalid), 128'(0));
      chk("release_round", 128'(b4.round), 128'(0));
      @(negedge clk);
      chk("start_not_queued", 128'(b4.ready), 128'(1));

      // start and out_ready on the same edge in DONE
      mode4 = 0;
      ordy_r[0] = 1'b0;
      run(0, PT_B, lat, ct);
      chk("b_zero_ct", ct, CT_B);
      @(negedge clk);
      st_r[0] = 1'b1;
      ordy_r[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("same_edge_idle", 128'(b4.ready), 128'(1));
      st_r[0] = 1'b0;
      @(negedge clk);
      chk("same_edge_stay", 128'(b4.ready), 128'(1));

      // Watchdog: round-3 key never valid
      mode4 = 2;
      pt_r[0] = PT_C;
      st_r[0] = 1'b1;
      @(posedge clk);
      #1 st_r[0] = 1'b0;
      n = 0;
      while (b4.key_idx != 4'd3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wd_reach_r3", 128'(b4.key_idx), 128'(3));
      for (int j = 0; j < 8; j++) begin
         chk("wd_no_alarm", 128'(b4.alarm), 128'(0));
         @(negedge clk);
      end
      chk("wd_alarm", 128'(b4.alarm), 128'(1));
      chk("wd_ready", 128'(b4.ready), 128'(1));
      chk("wd_sreg", b4.sreg, 128'h0);
      chk("wd_round", 128'(b4.round), 128'(0));
      chk("wd_ct_kept", b4.ciphertext, CT_B);
      @(negedge clk);
      chk("wd_alarm_pulse", 128'(b4.alarm), 128'(0));
      chk("wd_no_cvalid", 128'(b4.cvalid), 128'(0));

      // Asynchronous reset mid-block, then a clean block
      mode4 = 0;
      pt_r[0] = PT_B;
      st_r[0] = 1'b1;
      @(posedge clk);
      #1 st_r[0] = 1'b0;
      n = 0;
      while (b4.round != 4'd5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("ar_reach_r5", 128'(b4.round), 128'(5));
      #2 rst_n = 1'b0;
      #1;
      chk("ar_sreg", b4.sreg, 128'h0);
      chk("ar_round", 128'(b4.round), 128'(0));
      chk("ar_ready", 128'(b4.ready), 128'(1));
      chk("ar_ct", b4.ciphertext, 128'h0);
      chk("ar_keyidx", 128'(b4.key_idx), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run(0, PT_B, lat, ct);
      chk("ar_after_ct", ct, CT_B);
      chk("ar_after_lat", 128'(lat), 128'(40));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
